// File: rtl/bullet_ram_arbiter.sv
// ============================================================================
// bullet_ram_arbiter : round-robin owner arbiter for the shared bullet RAM port.
// Optional watchdog build: define BULLET_ARB_WATCHDOG_EN.       Rev 1.0
// ============================================================================
`default_nettype none

module bullet_ram_arbiter #(
  parameter int N_REQ    = 3,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 255
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        rd,
  input  logic [N_REQ-1:0]        we,
  input  logic [N_REQ*ADDR_W-1:0] addr_in,
  input  logic [N_REQ*DATA_W-1:0] wdata_in,
  output logic [N_REQ-1:0]        grant,
  output logic [N_REQ-1:0]        rvalid,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [DATA_W-1:0]       ram_wdata,
  output logic                    ram_we,
  output logic                    busy,
  output logic                    timeout
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_OWN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]   rvalid_q, rvalid_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   owner_idx;
  logic [PTR_W-1:0]   ptr_next;
  logic [N_REQ-1:0]   avail;
  logic               owner_drop;
  logic               hand_off;

`ifdef BULLET_ARB_WATCHDOG_EN
  localparam logic [7:0] C_HOLD_LIM = 8'(MAX_HOLD - 1);

  logic [7:0]         hold_q, hold_d;
  logic [N_REQ-1:0]   blocked_q, blocked_d;
  logic               timeout_q, timeout_d;
  logic               expire;
`endif

  // First set bit of r, scanning upward from p with wrap; p itself has priority.
  function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [PTR_W-1:0] p);
    logic [N_REQ-1:0] g;
    logic             found;
    g     = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!found && r[i] && (((int'(p) + k) % N_REQ) == i)) begin
          g[i]  = 1'b1;
          found = 1'b1;
        end
      end
    end
    return g;
  endfunction

  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) owner_idx = PTR_W'(i);
    end
  end

  assign ptr_next   = (owner_idx == PTR_W'(N_REQ - 1)) ? '0 : owner_idx + 1'b1;
  assign owner_drop = ~|(grant_q & req);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    rvalid_d = grant_q & rd;
    hand_off = 1'b0;
`ifdef BULLET_ARB_WATCHDOG_EN
    avail     = req & ~blocked_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    blocked_d = blocked_q & req;
    expire    = (hold_q == C_HOLD_LIM);
`else
    avail     = req;
`endif

    case (state_q)
      S_IDLE: begin
        if (|avail) begin
          grant_d = rr_pick(avail, ptr_q);
          state_d = S_OWN;
`ifdef BULLET_ARB_WATCHDOG_EN
          hold_d  = '0;
`endif
        end
      end

      S_OWN: begin
        hand_off = owner_drop;
`ifdef BULLET_ARB_WATCHDOG_EN
        hand_off = owner_drop | expire;
`endif
        if (hand_off) begin
          // Handoff happens on the release edge itself, searched from the advanced pointer.
          ptr_d   = ptr_next;
          grant_d = rr_pick(avail & ~grant_q, ptr_next);
          state_d = (|grant_d) ? S_OWN : S_IDLE;
`ifdef BULLET_ARB_WATCHDOG_EN
          hold_d  = '0;
          if (!owner_drop) begin
            timeout_d = 1'b1;
            blocked_d = blocked_d | grant_q;
          end
`endif
        end
`ifdef BULLET_ARB_WATCHDOG_EN
        else if (hold_q != 8'hFF) begin
          hold_d = hold_q + 8'd1;
        end
`endif
      end

      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      rvalid_q <= '0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rvalid_q <= rvalid_d;
      ptr_q    <= ptr_d;
    end
  end

`ifdef BULLET_ARB_WATCHDOG_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_q    <= '0;
      blocked_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      blocked_q <= blocked_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  // Without the watchdog there is no forced release, so timeout never fires.
  assign timeout = (MAX_HOLD < 0) ? 1'b1 : 1'b0;
`endif

  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) begin
        ram_addr  = addr_in[i*ADDR_W +: ADDR_W];
        ram_wdata = wdata_in[i*DATA_W +: DATA_W];
        ram_we    = we[i] & req[i];
      end
    end
  end

  assign grant  = grant_q;
  assign rvalid = rvalid_q;
  assign busy   = |grant_q;

endmodule

`default_nettype wire
